// File: rtl/ws_pixel_capture.sv
// Purpose: deserialize the first NUM_PIXELS*BITS_PER_PIXEL decoded bits of a frame into a display register, then flag passthrough.
// Latency: display loads on the edge sampling the final bit (LATCH_ON_RESET=0) or the frame-reset edge (LATCH_ON_RESET=1); valid pulses the following cycle.
// Backpressure: none; one bit strobe per cycle is accepted in every state, and frame reset takes priority over a coincident bit.
module ws_pixel_capture #(
    parameter int BITS_PER_PIXEL = 24,
    parameter int NUM_PIXELS     = 1,
    parameter int LATCH_ON_RESET = 0,
    parameter int CNT_W          = 16
) (
    input  logic                                 i_clk,
    input  logic                                 i_reset_n,
    input  logic                                 i_bit_valid,
    input  logic                                 i_bit,
    input  logic                                 i_treset,
    output logic [NUM_PIXELS*BITS_PER_PIXEL-1:0] o_pixel_data,
    output logic                                 o_pixel_valid,
    output logic                                 o_passthru_en,
    output logic [CNT_W-1:0]                     o_passthru_count
);

    localparam int TOTAL  = NUM_PIXELS * BITS_PER_PIXEL;
    localparam int BCNT_W = $clog2(TOTAL + 1);
    localparam int PIX_W  = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
    localparam int BIP_W  = (BITS_PER_PIXEL > 1) ? $clog2(BITS_PER_PIXEL) : 1;

    typedef enum logic {
        CAPTURE  = 1'b0,
        PASSTHRU = 1'b1
    } state_t;

    state_t                    state;
    logic [BCNT_W-1:0]         bit_cnt;
    logic [PIX_W-1:0]          pix_idx;
    logic [BIP_W-1:0]          bit_in_pix;
    logic [TOTAL-1:0]          cap_q;
    logic [TOTAL-1:0]          cap_next;
    logic [BITS_PER_PIXEL-1:0] slot_cur;
    logic [BITS_PER_PIXEL-1:0] slot_shifted;
    logic                      last_bit;

    // Passthrough enable is a pure decode of the state register.
    assign o_passthru_en = (state == PASSTHRU);

    // The final frame bit is the one that fills slot TOTAL-1 while capturing.
    assign last_bit = (state == CAPTURE) && (bit_cnt == BCNT_W'(TOTAL - 1));

    // Shift the incoming bit into the LSB of the current pixel slot so the first bit ends up as the MSB.
    always_comb begin
        cap_next     = cap_q;
        slot_cur     = cap_q[pix_idx*BITS_PER_PIXEL +: BITS_PER_PIXEL];
        slot_shifted = slot_cur << 1;
        slot_shifted[0] = i_bit;
        cap_next[pix_idx*BITS_PER_PIXEL +: BITS_PER_PIXEL] = slot_shifted;
    end

    // Frame FSM: capture, passthrough counting, display load and valid pulse.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state            <= CAPTURE;
            bit_cnt          <= '0;
            pix_idx          <= '0;
            bit_in_pix       <= '0;
            cap_q            <= '0;
            o_pixel_data     <= '0;
            o_pixel_valid    <= 1'b0;
            o_passthru_count <= '0;
        end else begin
            o_pixel_valid <= 1'b0;
            if (i_treset) begin
                // Only a completed capture may be latched; a partial frame is dropped.
                if ((LATCH_ON_RESET != 0) && (state == PASSTHRU)) begin
                    o_pixel_data  <= cap_q;
                    o_pixel_valid <= 1'b1;
                end
                state            <= CAPTURE;
                bit_cnt          <= '0;
                pix_idx          <= '0;
                bit_in_pix       <= '0;
                cap_q            <= '0;
                o_passthru_count <= '0;
            end else if (i_bit_valid) begin
                if (state == CAPTURE) begin
                    cap_q   <= cap_next;
                    bit_cnt <= bit_cnt + 1'b1;
                    if (last_bit) begin
                        // Pixel pointers park at zero so the slot select stays in range while forwarding.
                        state      <= PASSTHRU;
                        pix_idx    <= '0;
                        bit_in_pix <= '0;
                        if (LATCH_ON_RESET == 0) begin
                            o_pixel_data  <= cap_next;
                            o_pixel_valid <= 1'b1;
                        end
                    end else if (bit_in_pix == BIP_W'(BITS_PER_PIXEL - 1)) begin
                        bit_in_pix <= '0;
                        pix_idx    <= pix_idx + 1'b1;
                    end else begin
                        bit_in_pix <= bit_in_pix + 1'b1;
                    end
                end else if (o_passthru_count != '1) begin
                    o_passthru_count <= o_passthru_count + 1'b1;
                end
            end
        end
    end

endmodule
